// File: rtl/parity_checker_if.sv
// Bus between a serial parity-frame source and the parity_checker.
interface parity_checker_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 start;
  logic                 din;
  logic                 din_valid;
  logic                 busy;
  logic                 done;
  logic                 parity_ok;
  logic                 parity_err;
  logic [DATA_BITS-1:0] data_out;
  logic [7:0]           err_count;

  modport master (
    output start, din, din_valid,
    input  busy, done, parity_ok, parity_err, data_out, err_count
  );

  modport slave (
    input  start, din, din_valid,
    output busy, done, parity_ok, parity_err, data_out, err_count
  );
endinterface

// File: rtl/parity_checker.sv
// Serial frame receiver: DATA_BITS data bits (LSB first) plus one parity bit.
// Define ODD_PARITY_EN for odd parity; even parity otherwise.
module parity_checker #(
  parameter int unsigned DATA_BITS = 8
) (
  input logic             clk,
  input logic             rst,
  parity_checker_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam int unsigned ERR_W = 8;
`ifdef ODD_PARITY_EN
  localparam logic PAR_INV = 1'b1;
`else
  localparam logic PAR_INV = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [ERR_W-1:0]     errcnt_q, errcnt_d;

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      acc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      data_q   <= data_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Next-state and result logic; start wins over any accepted bit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    err_d    = err_q;
    data_d   = data_q;
    errcnt_d = errcnt_q;

    if (bus.start) begin
      state_d = S_DATA;
      cnt_d   = '0;
      shift_d = '0;
      acc_d   = 1'b0;
    end else if (bus.din_valid) begin
      case (state_q)
        S_DATA: begin
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (cnt_q == CNT_W'(i)) shift_d[i] = bus.din;
          end
          acc_d = acc_q ^ bus.din;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = S_PARITY;
        end
        S_PARITY: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          data_d  = shift_q;
          ok_d    = (bus.din == (acc_q ^ PAR_INV));
          err_d   = ~ok_d;
          // Saturate rather than wrap so a long error burst stays visible
          if (!ok_d && (errcnt_q != {ERR_W{1'b1}})) errcnt_d = errcnt_q + ERR_W'(1);
        end
        default: ;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.parity_ok  = ok_q;
  assign bus.parity_err = err_q;
  assign bus.data_out   = data_q;
  assign bus.err_count  = errcnt_q;

endmodule
